// File: rtl/game_screen_sequencer.sv
// Screen ownership controller for the Boggle/Sdoku game: routes every screen
// change through a frame-counted blanking interval that holds the screens in reset.
module game_screen_sequencer #(
  parameter int unsigned BLANK_FRAMES = 2,
  parameter logic [4:0]  KEY_NEXT     = 5'h1e,
  parameter logic [4:0]  KEY_OK       = 5'h1d,
  parameter logic [4:0]  KEY_ESC      = 5'h1f
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [4:0] key_pulse,
  input  logic       stage_clear,
  input  logic [1:0] sel_code,
  input  logic       sdoku_exit,
  output logic [2:0] screen,
  output logic       screen_rst,
  output logic [1:0] menu_sel,
  output logic       busy
);

  typedef enum logic [2:0] {
    SCR_MENU     = 3'd0,
    SCR_BOGGLE1  = 3'd1,
    SCR_BOGGLE2  = 3'd2,
    SCR_COMPLETE = 3'd3,
    SCR_SDOKU    = 3'd4,
    SCR_BLANK    = 3'd7
  } screen_e;

  generate
    if (BLANK_FRAMES == 0 || BLANK_FRAMES > 15) begin : g_bad_blank_frames
      $error("BLANK_FRAMES must lie in 1..15");
    end
  endgenerate

  localparam logic [3:0] BLANK_LOAD = 4'(BLANK_FRAMES);

  screen_e    screen_q, screen_d;
  screen_e    target_q, target_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] menu_sel_q, menu_sel_d;
  logic       screen_rst_q, screen_rst_d;
  logic       busy_q, busy_d;

  logic       req_vld;
  screen_e    req_tgt;
  logic       esc;

  always_comb begin
    screen_d     = screen_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    menu_sel_d   = menu_sel_q;
    screen_rst_d = screen_rst_q;
    busy_d       = busy_q;
    req_vld      = 1'b0;
    req_tgt      = SCR_MENU;
    esc          = (key_pulse == KEY_ESC);

    case (screen_q)
      SCR_BLANK: begin
        // Everything except frame_tick is ignored until the interval expires.
        if (frame_tick) begin
          if (cnt_q <= 4'd1) begin
            screen_d     = target_q;
            cnt_d        = 4'd0;
            screen_rst_d = 1'b0;
            busy_d       = 1'b0;
            if (target_q == SCR_MENU) menu_sel_d = 2'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      SCR_MENU: begin
        if (key_pulse == KEY_NEXT) begin
          menu_sel_d = (menu_sel_q == 2'd2) ? 2'd0 : menu_sel_q + 2'd1;
        end else if (key_pulse == KEY_OK) begin
          req_vld = 1'b1;
          case (menu_sel_q)
            2'd1:    req_tgt = SCR_SDOKU;
            2'd2:    req_tgt = SCR_BOGGLE2;
            default: req_tgt = SCR_BOGGLE1;
          endcase
        end
      end
      SCR_BOGGLE1: begin
        if (esc) begin
          req_vld = 1'b1;
          req_tgt = SCR_MENU;
        end else if (stage_clear) begin
          req_vld = 1'b1;
          req_tgt = SCR_BOGGLE2;
        end
      end
      SCR_BOGGLE2: begin
        if (esc) begin
          req_vld = 1'b1;
          req_tgt = SCR_MENU;
        end else if (stage_clear) begin
          req_vld = 1'b1;
          req_tgt = SCR_COMPLETE;
        end
      end
      SCR_COMPLETE: begin
        if (esc) begin
          req_vld = 1'b1;
          req_tgt = SCR_MENU;
        end else begin
          case (sel_code)
            2'b00: begin
              req_vld = 1'b1;
              req_tgt = SCR_BOGGLE2;
            end
            2'b01: begin
              req_vld = 1'b1;
              req_tgt = SCR_MENU;
            end
            2'b10: begin
              req_vld = 1'b1;
              req_tgt = SCR_SDOKU;
            end
            default: ;
          endcase
        end
      end
      SCR_SDOKU: begin
        if (esc || sdoku_exit) begin
          req_vld = 1'b1;
          req_tgt = SCR_MENU;
        end
      end
      default: screen_d = SCR_MENU;
    endcase

    if (req_vld) begin
      target_d     = req_tgt;
      cnt_d        = BLANK_LOAD;
      screen_d     = SCR_BLANK;
      screen_rst_d = 1'b1;
      busy_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      screen_q     <= SCR_MENU;
      target_q     <= SCR_MENU;
      cnt_q        <= 4'd0;
      menu_sel_q   <= 2'd0;
      screen_rst_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      screen_q     <= screen_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      menu_sel_q   <= menu_sel_d;
      screen_rst_q <= screen_rst_d;
      busy_q       <= busy_d;
    end
  end

  assign screen     = screen_q;
  assign screen_rst = screen_rst_q;
  assign menu_sel   = menu_sel_q;
  assign busy       = busy_q;

endmodule
